speed_select_arbiter: RTL and testbench
=======================================

// Module: speed_select_arbiter
// PURPOSE
//  Turns the three speed push-buttons into one speed setting and the target-move tick.
//  - Debounces the active-low speed1/speed2/speed3 buttons and resolves simultaneous presses.
//  - Holds the selected speed level and emits a one-cycle move_tick at 2 s / 1.5 s / 1 s.
//  - Sits between the board buttons and the game controller and replaces its three
//    free-running slow clocks with a single clock-enable on clk.
// PARAMETERS
//  CLK_HZ       50_000_000  system clock frequency in Hz
//  DEBOUNCE_MS  20          time a button must be stable before its level is accepted
//  PERIOD0_MS   2000        move period at speed level 0 (speed1)
//  PERIOD1_MS   1500        move period at speed level 1 (speed2)
//  PERIOD2_MS   1000        move period at speed level 2 (speed3)
// PORTS
//  clk            in   1  system clock; the only clock in the block
//  rst_n          in   1  reset, asynchronous assert, active-low
//  speed1         in   1  button, active-low, asynchronous to clk
//  speed2         in   1  button, active-low, asynchronous to clk
//  speed3         in   1  button, active-low, asynchronous to clk
//  game_over      in   1  high = game finished; freezes selection and ticks
//  speed_level    out  2  selected level: 0, 1 or 2; 3 is never driven
//  move_tick      out  1  one-cycle pulse, once per period of the selected level
//  speed_changed  out  1  one-cycle pulse when speed_level takes a new value
// BEHAVIOUR
//  Reset
//  - rst_n low clears everything immediately, regardless of clk.
//  - Outputs after reset: speed_level=0, move_tick=0, speed_changed=0.
//  - Period counter=0; synchronisers and debounced levels = released (1).
//  Debounce
//  - Each button passes through a 2-flop synchroniser.
//  - DEB_CYC = CLK_HZ/1000*DEBOUNCE_MS.
//  - The debounced level updates only after the synchronised input has held a new value
//    for DEB_CYC consecutive cycles. Any toggle before that restarts the count.
//  - A press event is a 1->0 transition of the debounced level.
//  - Holding a button or releasing it produces no event.
//  Arbitration
//  - If events occur in the same cycle, the fixed priority is speed1 > speed2 > speed3.
//  - The winning event index becomes the new speed_level on the next edge.
//  - Events that lose arbitration are dropped, not queued.
//  - Latency from a clean press to the speed_level update: 2 + DEB_CYC + 1 cycles.
//  - If the winner equals the current speed_level: no change, no speed_changed pulse,
//    and the tick phase is untouched.
//  - If the winner differs: speed_changed pulses for one cycle, aligned with the
//    speed_level update, and the period counter restarts at 0.
//  Tick generation
//  - PERx = CLK_HZ/1000*PERIODx_MS. The counter runs 0..PER(level)-1.
//  - move_tick=1 in the cycle the counter equals PER(level)-1; the counter then wraps to 0.
//  - The first tick comes exactly PER cycles after reset release or after a speed change.
//  - Counter width = $clog2(PER0). Arithmetic is unsigned with no overflow, since PER0 is
//    the maximum period.
//  Simultaneous events
//  - If a speed change and the terminal count fall in the same cycle, the old period's
//    move_tick still fires and the counter restarts at 0.
//  game_over
//  - While game_over=1: press events are ignored, move_tick=0, and the counter is held at 0.
//  - speed_level keeps its value.
//  - On game_over 1->0 the first tick comes PER cycles later.
//  - Debouncers keep running throughout.
// STRUCTURE
//  Shared package game_pkg:
//  - typedef logic [1:0] speed_t.
//  - Constants SPEED_L0=0, SPEED_L1=1, SPEED_L2=2.
//  - Function ms_to_cycles(clk_hz, ms).
//  Sub-module button_debouncer:
//  - Contains the synchroniser, the stability counter and the falling-edge detect.
//  - Outputs a press pulse; instantiated three times.
//  The top of the block holds the arbiter, the speed_level register and the period counter.
// TESTING  (CLK_HZ=1000, DEBOUNCE_MS=4, PERIOD0/1/2_MS=20/15/10)
//  1. Release reset with buttons idle -> speed_level=0; move_tick at cycles 20, 40, 60;
//     speed_changed never asserts.
//  2. Drive speed3 low and hold it -> speed_level=2 and speed_changed pulse 7 cycles after
//     the press; next ticks 10 and 20 cycles after the change.
//  3. speed2 bounces low for 3 cycles, high for 1, then stays low -> no change for the
//     glitch; speed_level=1 once it has been stable for 4 cycles.
//  4. speed2 and speed3 pressed in the same cycle -> speed_level=1, one speed_changed.
//     Then press speed1 while at level 0 -> no pulse and the tick cadence is unchanged.
//  5. Set game_over=1 mid-period, then press speed3 -> no ticks and speed_level unchanged.
//     Clear game_over -> first tick 20 cycles later.
//  6. Assert rst_n low mid-period at speed_level=2 -> all outputs 0 immediately.
//     Release -> first tick after 20 cycles.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and helpers for the game-side blocks: speed encoding and ms-to-cycle conversion.
package game_pkg;

  typedef logic [1:0] speed_t;

  localparam speed_t SPEED_L0 = 2'd0;
  localparam speed_t SPEED_L1 = 2'd1;
  localparam speed_t SPEED_L2 = 2'd2;

  localparam int NUM_BTN = 3;

  // Result of arbitrating one cycle's press events.
  typedef struct packed {
    logic   hit;
    speed_t level;
  } speed_req_t;

  function automatic int ms_to_cycles(input int clk_hz, input int ms);
    return clk_hz / 1000 * ms;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// One active-low push-button: 2-flop synchroniser, stability counter, press pulse on the
// accepted 1->0 transition of the debounced level.
module button_debouncer #(
  parameter int DEB_CYC = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic press
);

  localparam int CW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

  logic          sync1, sync2, level;
  logic [CW-1:0] cnt;
  logic          settle;

  // The synchronised input has differed from the accepted level for DEB_CYC cycles.
  assign settle = (sync2 != level) && (cnt == CW'(DEB_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
      press <= settle & level;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (settle) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/speed_select_arbiter.sv
// Speed button front-end: debounced presses pick speed_level (speed1 > speed2 > speed3),
// and a single period counter on clk produces the move_tick clock-enable.
module speed_select_arbiter
  import game_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int PERIOD0_MS  = 2000,
  parameter int PERIOD1_MS  = 1500,
  parameter int PERIOD2_MS  = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       speed1,
  input  logic       speed2,
  input  logic       speed3,
  input  logic       game_over,
  output logic [1:0] speed_level,
  output logic       move_tick,
  output logic       speed_changed
);

  localparam int DEB_CYC = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);
  localparam int PER0    = ms_to_cycles(CLK_HZ, PERIOD0_MS);
  localparam int PER1    = ms_to_cycles(CLK_HZ, PERIOD1_MS);
  localparam int PER2    = ms_to_cycles(CLK_HZ, PERIOD2_MS);
  localparam int CW      = $clog2(PER0);

  logic [NUM_BTN-1:0] btn_n;
  logic [NUM_BTN-1:0] press;

  assign btn_n = {speed3, speed2, speed1};

  generate
    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
      button_debouncer #(.DEB_CYC(DEB_CYC)) u_deb (
        .clk   (clk),
        .rst_n (rst_n),
        .btn_n (btn_n[i]),
        .press (press[i])
      );
    end
  endgenerate

  speed_req_t    req;
  logic          change;
  logic [CW-1:0] cnt;
  logic [CW-1:0] per_last;

  // Losing events are simply dropped; game_over masks all of them.
  always_comb begin
    req = '0;
    if (!game_over) begin
      if (press[0]) begin
        req.hit   = 1'b1;
        req.level = SPEED_L0;
      end else if (press[1]) begin
        req.hit   = 1'b1;
        req.level = SPEED_L1;
      end else if (press[2]) begin
        req.hit   = 1'b1;
        req.level = SPEED_L2;
      end
    end
  end

  always_comb begin
    case (speed_level)
      SPEED_L1: per_last = CW'(PER1 - 1);
      SPEED_L2: per_last = CW'(PER2 - 1);
      default:  per_last = CW'(PER0 - 1);
    endcase
  end

  assign change    = req.hit && (req.level != speed_level);
  assign move_tick = !game_over && (cnt == per_last);

  // A change landing on the terminal count still lets the old tick out; both restart at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      speed_level   <= SPEED_L0;
      speed_changed <= 1'b0;
      cnt           <= '0;
    end else begin
      speed_changed <= change;
      if (change) speed_level <= req.level;
      if (game_over || change || (cnt == per_last)) cnt <= '0;
      else                                          cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_speed_select_arbiter.sv
// Bench for speed_select_arbiter: directed scenarios plus random button/game_over traffic,
// all checked every cycle against a window-based behavioural model.
module tb_speed_select_arbiter;

  localparam int CLK_HZ = 1000;
  localparam int DEB_MS = 4;
  localparam int P0 = 20, P1 = 15, P2 = 10;
  localparam int D  = CLK_HZ / 1000 * DEB_MS;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       game_over = 1'b0;
  logic [2:0] btn = 3'b111;
  logic [1:0] speed_level;
  logic       move_tick, speed_changed;

  int n_chk = 0, n_fail = 0;
  int n_tick = 0, n_pulse = 0;

  speed_select_arbiter #(
    .CLK_HZ(CLK_HZ), .DEBOUNCE_MS(DEB_MS),
    .PERIOD0_MS(P0), .PERIOD1_MS(P1), .PERIOD2_MS(P2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .speed1        (btn[0]),
    .speed2        (btn[1]),
    .speed3        (btn[2]),
    .game_over     (game_over),
    .speed_level   (speed_level),
    .move_tick     (move_tick),
    .speed_changed (speed_changed)
  );

  always #5 clk = ~clk;

  // Reference model: a button's accepted level flips once its last D synchronised
  // samples (inputs seen two edges earlier) all disagree with it.
  int  per_of[3] = '{P0, P1, P2};
  bit  hist[3][D+2];
  bit  deb_m[3];
  bit  pend[3];
  int  lvl_m, n_m, start_m;
  bit  chg_m;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 3; b++) begin
        for (int i = 0; i < D + 2; i++) hist[b][i] = 1'b1;
        deb_m[b] = 1'b1;
        pend[b]  = 1'b0;
      end
      lvl_m = 0; chg_m = 0; n_m = 0; start_m = 0;
    end else begin
      int w;
      bit flip;
      n_m++;
      chg_m = 0;
      w = -1;
      if (!game_over)
        for (int b = 0; b < 3; b++) if (pend[b] && w < 0) w = b;
      if (w >= 0 && w != lvl_m) begin
        lvl_m = w; chg_m = 1; start_m = n_m;
      end
      if (game_over) start_m = n_m;
      for (int b = 0; b < 3; b++) begin
        for (int i = D + 1; i > 0; i--) hist[b][i] = hist[b][i-1];
        hist[b][0] = btn[b];
        pend[b] = 1'b0;
        flip = 1'b1;
        for (int i = 2; i < D + 2; i++) if (hist[b][i] == deb_m[b]) flip = 1'b0;
        if (flip) begin
          pend[b]  = deb_m[b];
          deb_m[b] = !deb_m[b];
        end
      end
    end
  end

  function automatic int exp_tick();
    return (!game_over && ((n_m - start_m) % per_of[lvl_m]) == per_of[lvl_m] - 1) ? 1 : 0;
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    chk("level", speed_level, lvl_m);
    chk("tick", move_tick, exp_tick());
    chk("changed", speed_changed, chg_m);
    n_tick  += int'(move_tick);
    n_pulse += int'(speed_changed);
  endtask

  task automatic hold(input logic [2:0] v, input int n);
    btn = v;
    repeat (n) cyc();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_level", speed_level, 0);
    chk("rst_tick", move_tick, 0);
    chk("rst_changed", speed_changed, 0);
    rst_n = 1'b1;

    // Idle: ticks every 20 cycles, no level change.
    n_pulse = 0;
    for (int k = 1; k <= 60; k++) begin
      cyc();
      if (k % 20 == 19) chk("t1_tick", move_tick, 1);
    end
    chk("t1_pulses", n_pulse, 0);

    // speed3 held: change 7 cycles after the press, ticks 10 and 20 cycles later.
    btn = 3'b011;
    repeat (6) cyc();
    chk("t2_early", speed_level, 0);
    cyc();
    chk("t2_level", speed_level, 2);
    chk("t2_pulse", speed_changed, 1);
    repeat (9) cyc();
    chk("t2_tick1", move_tick, 1);
    repeat (10) cyc();
    chk("t2_tick2", move_tick, 1);
    hold(3'b111, 10);

    // speed2 glitch (3 low, 1 high) is rejected; the stable run is accepted.
    hold(3'b101, 3);
    hold(3'b111, 1);
    hold(3'b101, 6);
    chk("t3_glitch", speed_level, 2);
    cyc();
    chk("t3_level", speed_level, 1);
    hold(3'b111, 10);

    // Back to level 0, then speed2+speed3 together, then speed1 twice.
    hold(3'b110, 8);
    hold(3'b111, 10);
    chk("t4_l0", speed_level, 0);
    n_pulse = 0;
    hold(3'b001, 8);
    hold(3'b111, 10);
    chk("t4_simul", speed_level, 1);
    chk("t4_pulses", n_pulse, 1);
    hold(3'b110, 8);
    hold(3'b111, 10);
    n_pulse = 0;
    hold(3'b110, 8);
    hold(3'b111, 10);
    chk("t4_same_lvl", speed_level, 0);
    chk("t4_same_pulse", n_pulse, 0);

    // game_over masks presses and ticks; the period restarts when it clears.
    repeat (5) cyc();
    game_over = 1'b1;
    n_tick = 0;
    hold(3'b011, 8);
    hold(3'b111, 25);
    chk("t5_ticks", n_tick, 0);
    chk("t5_level", speed_level, 0);
    game_over = 1'b0;
    repeat (18) cyc();
    chk("t5_early", move_tick, 0);
    cyc();
    chk("t5_tick", move_tick, 1);

    // Asynchronous reset mid-period at level 2.
    hold(3'b011, 8);
    hold(3'b111, 10);
    chk("t6_l2", speed_level, 2);
    repeat (3) cyc();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_level", speed_level, 0);
    chk("t6_rst_tick", move_tick, 0);
    chk("t6_rst_changed", speed_changed, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (18) cyc();
    chk("t6_early", move_tick, 0);
    cyc();
    chk("t6_tick", move_tick, 1);

    // Random traffic: alternating calm and bouncy phases, occasional game_over toggles.
    for (int ph = 0; ph < 16; ph++) begin
      int p;
      p = (ph % 2 == 1) ? 30 : 4;
      repeat (200) begin
        for (int b = 0; b < 3; b++)
          if ($urandom_range(0, 99) < p) btn[b] = ~btn[b];
        if ($urandom_range(0, 149) == 0) game_over = ~game_over;
        cyc();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end

endmodule
